mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single 128-bit block memory port between the instruction cache and the data cache.
- Each cache sees a private memory port with the same read/write/addr/wdata/rdata/ready protocol as the raw memory.
- Sits between the two cache instances and the memory model at the top level.
- Grants whole transactions. A grant is held until mem_ready, with no interleaving.

Parameters:
- ADDR_W, 28, block address width.
- DATA_W, 128, block data width.

Ports:
- clk  input  1  system clock, rising edge.
- proc_reset  input  1  synchronous, active-high reset.
- i_read  input  1  I-cache block read request.
- i_write  input  1  I-cache block write request.
- i_addr  input  ADDR_W  I-cache block address.
- i_wdata  input  DATA_W  I-cache write data.
- i_rdata  output  DATA_W  read data to I-cache.
- i_ready  output  1  transaction-done pulse to I-cache.
- d_read, d_write, d_addr, d_wdata, d_rdata, d_ready  same widths and meanings as the i_* ports, for the D-cache.
- mem_read  output  1  read request to memory.
- mem_write  output  1  write request to memory.
- mem_addr  output  ADDR_W  address to memory.
- mem_wdata  output  DATA_W  write data to memory.
- mem_rdata  input  DATA_W  read data from memory.
- mem_ready  input  1  memory done pulse.

Behaviour:
- Clocking and reset: one clock, clk. Reset proc_reset is synchronous and active-high; all registers update on the rising edge of clk.
- Requests: requester X requests when X_read|X_write = 1. Requesters hold the request stable until they see X_ready.
- States: IDLE, GNT_I, GNT_D. A 2-bit state register is plus one last-grant flag.
- Reset:
  - state=IDLE, last-grant=D.
  - mem_read=mem_write=0, mem_addr=0, mem_wdata=0.
  - i_ready=d_ready=0, i_rdata=d_rdata=0.
  - Outputs reach these values in the cycle after the reset edge.
- IDLE:
  - All mem_* outputs and both *_ready outputs are 0.
  - Only one request pending: go to that requester's grant state.
  - Both pending: go to GNT_D (fixed D priority, base build).
  - mem_ready seen in IDLE is ignored and not routed.
- GNT_X:
  - mem_read/mem_write/mem_addr/mem_wdata are combinationally equal to X_read/X_write/X_addr/X_wdata.
  - X_rdata = mem_rdata and X_ready = mem_ready.
  - The other requester's ready = 0 and rdata = 0.
- GNT_X exits:
  - mem_ready=1: next state IDLE; last-grant=X.
  - X_read|X_write drops to 0 before mem_ready (abort): next state IDLE; mem_* outputs return to 0 the next cycle.
- Latency: a request arriving in IDLE reaches mem_* one cycle later. At least one IDLE cycle separates consecutive grants; this is the bubble in which each cache deasserts its request after ready.
- X_read and X_write both high: forwarded unchanged; the memory model resolves it.
- Reset during a grant: next state IDLE and outputs zero, regardless of mem_ready.
- No combinational path from mem_ready to mem_* outputs.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: a tie in IDLE grants the requester that is NOT last-grant (round-robin); single-request cases are unchanged.
- Undefined: a tie always goes to the D-cache and last-grant is unused. Synthesis may prune it.

Test Plan:
- Reset, then I-cache only: i_read=1, i_addr=28'h0000123; memory returns 128'hA5 with mem_ready after 4 cycles.
  -> mem_read=1 and mem_addr=28'h0000123 from cycle+1; i_rdata=128'hA5 and i_ready=1 in the mem_ready cycle; d_ready=0 throughout.
- D-cache write only: d_write=1, d_addr=28'h00000FF, d_wdata=128'h1234.
  -> mem_write=1 with matching addr/wdata; d_ready follows mem_ready; the arbiter is in IDLE the following cycle.
- Simultaneous i_read and d_read from IDLE, base build.
  -> D served first; after D's mem_ready, one IDLE cycle, then GNT_I with mem_addr=i_addr.
- Same as previous, with MEM_ARB_RR_EN defined and last-grant=D.
  -> I served first. Repeating the tie after that -> D served.
- Abort and stray ready: in GNT_I, drop i_read before mem_ready -> mem_read=0 the next cycle and state IDLE. Pulse mem_ready in IDLE -> i_ready=d_ready=0.
- Reset mid-grant: assert proc_reset while mem_write=1 in GNT_D -> all mem_* outputs 0 the next cycle and no ready pulse.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one block memory port between I-cache and D-cache.
// Whole-transaction grants, held until mem_ready or until the requester aborts.
//
// Ports:
//   clk, proc_reset                 clock, synchronous active-high reset
//   i_read/i_write/i_addr/i_wdata   I-cache request side
//   i_rdata/i_ready                 I-cache response side
//   d_*                             same set for the D-cache
//   mem_read/mem_write/mem_addr     request to the memory
//   mem_wdata                       write data to the memory
//   mem_rdata/mem_ready             response from the memory
//
// Build option: define MEM_ARB_RR_EN to resolve simultaneous requests
// round-robin on the last grant. Without it, D-cache always wins a tie.
module mem_port_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t state;
    logic   i_req;
    logic   d_req;
    state_t tie_winner;

    assign i_req = i_read | i_write;
    assign d_req = d_read | d_write;

`ifdef MEM_ARB_RR_EN
    // Set when the D-cache completed the most recent transaction.
    logic last_d;

    assign tie_winner = last_d ? GNT_I : GNT_D;
`else
    assign tie_winner = GNT_D;
`endif

    // Grant state. An abort (request dropped before mem_ready) returns to
    // IDLE without updating the last-grant record.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state <= IDLE;
`ifdef MEM_ARB_RR_EN
            last_d <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_req && d_req) state <= tie_winner;
                    else if (i_req)     state <= GNT_I;
                    else if (d_req)     state <= GNT_D;
                end
                GNT_I: begin
                    if (mem_ready) begin
                        state <= IDLE;
`ifdef MEM_ARB_RR_EN
                        last_d <= 1'b0;
`endif
                    end else if (!i_req) begin
                        state <= IDLE;
                    end
                end
                GNT_D: begin
                    if (mem_ready) begin
                        state <= IDLE;
`ifdef MEM_ARB_RR_EN
                        last_d <= 1'b1;
`endif
                    end else if (!d_req) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Port muxing depends only on the registered state and the granted
    // requester's inputs, so mem_ready never reaches the mem_* outputs.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_rdata   = '0;
        i_ready   = 1'b0;
        d_rdata   = '0;
        d_ready   = 1'b0;
        case (state)
            GNT_I: begin
                mem_read  = i_read;
                mem_write = i_write;
                mem_addr  = i_addr;
                mem_wdata = i_wdata;
                i_rdata   = mem_rdata;
                i_ready   = mem_ready;
            end
            GNT_D: begin
                mem_read  = d_read;
                mem_write = d_write;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                d_rdata   = mem_rdata;
                d_ready   = mem_ready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed per-cycle vectors for mem_port_arbiter.
// Covers single requests, ties, abort, stray ready and reset mid-grant.
module tb_mem_port_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk;
    logic          proc_reset;
    logic          i_read, i_write, d_read, d_write;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [DW-1:0] i_wdata, d_wdata, i_rdata, d_rdata;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          i_ready, d_ready;
    logic          mem_read, mem_write, mem_ready;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .i_read     (i_read),
        .i_write    (i_write),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .i_rdata    (i_rdata),
        .i_ready    (i_ready),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_ready    (d_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs for one cycle, then the outputs required during that cycle.
    typedef struct {
        logic          rst;
        logic          ir;
        logic          iw;
        logic [AW-1:0] ia;
        logic [DW-1:0] iwd;
        logic          dr;
        logic          dw;
        logic [AW-1:0] da;
        logic [DW-1:0] dwd;
        logic [DW-1:0] mrd;
        logic          mrdy;
        logic          emr;
        logic          emw;
        logic [AW-1:0] ema;
        logic [DW-1:0] emwd;
        logic [DW-1:0] eir;
        logic          eiry;
        logic [DW-1:0] edr;
        logic          edry;
    } vec_t;

    localparam logic [AW-1:0] IA  = 28'h0000123;
    localparam logic [AW-1:0] IA2 = 28'h0000321;
    localparam logic [AW-1:0] DA  = 28'h00000FF;
    localparam logic [AW-1:0] DA2 = 28'h0000456;
    localparam logic [DW-1:0] IWD = 128'hC0DE;
    localparam logic [DW-1:0] DWD = 128'h1234;
    localparam logic [DW-1:0] Z   = '0;

    vec_t tbl[$];

    // Drive at the falling edge, compare 1 ns later, before the rising edge.
    task automatic run(input vec_t v, input string name);
        logic [416-1:0] got;
        logic [416-1:0] exp;
        @(negedge clk);
        proc_reset = v.rst;
        i_read     = v.ir;
        i_write    = v.iw;
        i_addr     = v.ia;
        i_wdata    = v.iwd;
        d_read     = v.dr;
        d_write    = v.dw;
        d_addr     = v.da;
        d_wdata    = v.dwd;
        mem_rdata  = v.mrd;
        mem_ready  = v.mrdy;
        #1;
        got = {mem_read, mem_write, mem_addr, mem_wdata,
               i_rdata, i_ready, d_rdata, d_ready};
        exp = {v.emr, v.emw, v.ema, v.emwd,
               v.eir, v.eiry, v.edr, v.edry};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    initial begin
        // rst ir iw ia iwd | dr dw da dwd | mrd mrdy |
        // emr emw ema emwd | eir eiry | edr edry
        tbl.push_back(vec_t'{0, 0,0,Z[27:0],Z, 0,0,Z[27:0],Z, Z,0,
                             0,0,Z[27:0],Z, Z,0, Z,0});
        // I-cache read, memory answers on the 4th grant cycle
        tbl.push_back(vec_t'{0, 1,0,IA,IWD, 0,0,DA,DWD, Z,0,
                             0,0,Z[27:0],Z, Z,0, Z,0});
        tbl.push_back(vec_t'{0, 1,0,IA,IWD, 0,0,DA,DWD, Z,0,
                             1,0,IA,IWD, Z,0, Z,0});
        tbl.push_back(vec_t'{0, 1,0,IA,IWD, 0,0,DA,DWD, 128'h11,0,
                             1,0,IA,IWD, 128'h11,0, Z,0});
        tbl.push_back(vec_t'{0, 1,0,IA,IWD, 0,0,DA,DWD, Z,0,
                             1,0,IA,IWD, Z,0, Z,0});
        tbl.push_back(vec_t'{0, 1,0,IA,IWD, 0,0,DA,DWD, 128'hA5,1,
                             1,0,IA,IWD, 128'hA5,1, Z,0});
        tbl.push_back(vec_t'{0, 0,0,IA,IWD, 0,0,DA,DWD, 128'hA5,0,
                             0,0,Z[27:0],Z, Z,0, Z,0});
        // D-cache write
        tbl.push_back(vec_t'{0, 0,0,IA,IWD, 0,1,DA,DWD, Z,0,
                             0,0,Z[27:0],Z, Z,0, Z,0});
        tbl.push_back(vec_t'{0, 0,0,IA,IWD, 0,1,DA,DWD, Z,0,
                             0,1,DA,DWD, Z,0, Z,0});
        tbl.push_back(vec_t'{0, 0,0,IA,IWD, 0,1,DA,DWD, 128'h55,1,
                             0,1,DA,DWD, Z,0, 128'h55,1});
        tbl.push_back(vec_t'{0, 0,0,IA,IWD, 0,0,DA,DWD, 128'h55,0,
                             0,0,Z[27:0],Z, Z,0, Z,0});
        // Tie in IDLE; last grant so far is D
        tbl.push_back(vec_t'{0, 1,0,IA,IWD, 1,0,DA2,DWD, Z,0,
                             0,0,Z[27:0],Z, Z,0, Z,0});
`ifdef MEM_ARB_RR_EN
        tbl.push_back(vec_t'{0, 1,0,IA,IWD, 1,0,DA2,DWD, Z,0,
                             1,0,IA,IWD, Z,0, Z,0});
        tbl.push_back(vec_t'{0, 1,0,IA,IWD, 1,0,DA2,DWD, 128'h88,1,
                             1,0,IA,IWD, 128'h88,1, Z,0});
        // both still requesting: second tie, last grant now I
        tbl.push_back(vec_t'{0, 1,0,IA,IWD, 1,0,DA2,DWD, Z,0,
                             0,0,Z[27:0],Z, Z,0, Z,0});
        tbl.push_back(vec_t'{0, 1,0,IA,IWD, 1,0,DA2,DWD, Z,0,
                             1,0,DA2,DWD, Z,0, Z,0});
        tbl.push_back(vec_t'{0, 1,0,IA,IWD, 1,0,DA2,DWD, 128'h77,1,
                             1,0,DA2,DWD, Z,0, 128'h77,1});
`else
        tbl.push_back(vec_t'{0, 1,0,IA,IWD, 1,0,DA2,DWD, Z,0,
                             1,0,DA2,DWD, Z,0, Z,0});
        tbl.push_back(vec_t'{0, 1,0,IA,IWD, 1,0,DA2,DWD, 128'h77,1,
                             1,0,DA2,DWD, Z,0, 128'h77,1});
        tbl.push_back(vec_t'{0, 1,0,IA,IWD, 0,0,DA2,DWD, Z,0,
                             0,0,Z[27:0],Z, Z,0, Z,0});
        tbl.push_back(vec_t'{0, 1,0,IA,IWD, 0,0,DA2,DWD, Z,0,
                             1,0,IA,IWD, Z,0, Z,0});
        tbl.push_back(vec_t'{0, 1,0,IA,IWD, 0,0,DA2,DWD, 128'h88,1,
                             1,0,IA,IWD, 128'h88,1, Z,0});
`endif
        tbl.push_back(vec_t'{0, 0,0,IA,IWD, 0,0,DA2,DWD, Z,0,
                             0,0,Z[27:0],Z, Z,0, Z,0});

        proc_reset = 1'b1;
        i_read = 0; i_write = 0; i_addr = '0; i_wdata = '0;
        d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; mem_ready = 0;
        repeat (2) @(posedge clk);

        foreach (tbl[k]) run(tbl[k], $sformatf("row%0d", k));

        // Abort in GNT_I, then a stray mem_ready in IDLE
        run(vec_t'{0, 1,0,IA2,Z, 0,0,DA,DWD, Z,0,
                   0,0,Z[27:0],Z, Z,0, Z,0}, "abort_req");
        run(vec_t'{0, 1,0,IA2,Z, 0,0,DA,DWD, Z,0,
                   1,0,IA2,Z, Z,0, Z,0}, "abort_gnt");
        run(vec_t'{0, 0,0,IA2,Z, 0,0,DA,DWD, Z,0,
                   0,0,IA2,Z, Z,0, Z,0}, "abort_drop");
        run(vec_t'{0, 0,0,IA2,Z, 0,0,DA,DWD, 128'h99,1,
                   0,0,Z[27:0],Z, Z,0, Z,0}, "stray_ready");

        // Reset while GNT_D is driving a write
        run(vec_t'{0, 0,0,IA,IWD, 0,1,DA,DWD, Z,0,
                   0,0,Z[27:0],Z, Z,0, Z,0}, "rst_req");
        run(vec_t'{1, 0,0,IA,IWD, 0,1,DA,DWD, Z,0,
                   0,1,DA,DWD, Z,0, Z,0}, "rst_gnt");
        run(vec_t'{0, 0,0,IA,IWD, 0,0,DA,DWD, 128'h55,1,
                   0,0,Z[27:0],Z, Z,0, Z,0}, "rst_after");
        run(vec_t'{0, 0,0,IA,IWD, 0,0,DA,DWD, Z,0,
                   0,0,Z[27:0],Z, Z,0, Z,0}, "rst_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
